// File: rtl/ntt_stage_sequencer_pkg.sv
// Shared NTT control definitions: mode encodings, transform size, the
// sequencer FSM state type and a stage-to-mode decode helper.
package ntt_stage_sequencer_pkg;

  localparam int unsigned LOG_N   = 12;
  localparam int unsigned LOG_M_W = 4;

  // Twiddle mode encodings understood by ntt_core.
  localparam logic [1:0] MODE_CORE = 2'd0;
  localparam logic [1:0] MODE_I    = 2'd1;
  localparam logic [1:0] MODE_ADDR = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Twiddle mode used by the cores for a given stage index.
  function automatic logic [1:0] mode_of(input logic [LOG_M_W-1:0] log_m,
                                         input int unsigned mode1_start,
                                         input int unsigned mode2_start);
    int unsigned lm;
    lm = 32'(log_m);
    if (lm < mode1_start)      return MODE_CORE;
    else if (lm < mode2_start) return MODE_I;
    else                       return MODE_ADDR;
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_delay.sv
// ntt_ctrl_delay: fixed-depth shift register with asynchronous clear, used to
// align write-back control with the ntt_core pipeline.
// Ports: i_clk, i_rst (async, active-high), i_d (WIDTH), o_q (i_d delayed DEPTH cycles).
module ntt_ctrl_delay #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int j = 0; j < int'(DEPTH); j++) r_pipe[j] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int j = 1; j < int'(DEPTH); j++) r_pipe[j] <= r_pipe[j-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences the broadcast ntt_core controls through one forward NTT: sweeps
// read addresses per stage, steps log_m, selects twiddle mode, drains the core
// pipeline between stages and emits delayed write-back controls.
// Ports: i_clk, i_rst (async, active-high), i_start (accepted only when idle),
//        o_busy, o_done (1-cycle pulse), o_log_m, o_i, o_mode,
//        o_upper/lower_read_address, o_write_enable, o_upper/lower_write_address.
module ntt_stage_sequencer
  import ntt_stage_sequencer_pkg::*;
#(
  parameter int unsigned LOG_N_P      = LOG_N,
  parameter int unsigned WORDS        = 512,
  parameter int unsigned PIPE_LATENCY = 8,
  parameter int unsigned MODE1_START  = 5,
  parameter int unsigned MODE2_START  = 10,
  localparam int unsigned AW          = $clog2(WORDS)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic [LOG_M_W-1:0] o_log_m,
  output logic [AW:0]        o_i,
  output logic [1:0]         o_mode,
  output logic [AW-1:0]      o_upper_read_address,
  output logic [AW-1:0]      o_lower_read_address,
  output logic               o_write_enable,
  output logic [AW-1:0]      o_upper_write_address,
  output logic [AW-1:0]      o_lower_write_address
);

  localparam int unsigned NUM_STAGES = LOG_N_P;
  localparam int unsigned DW         = $clog2(PIPE_LATENCY + 1);

  state_e             r_state, w_state_d;
  logic [AW-1:0]      r_k, w_k_d;
  logic [DW-1:0]      r_d, w_d_d;
  logic [LOG_M_W-1:0] r_log_m, w_log_m_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic [1:0]         r_mode, w_mode_d;
  logic [AW:0]        r_i, w_i_d;

  logic               w_read_valid;
  logic [AW-1:0]      w_read_addr;
  logic [AW:0]        w_wb;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_k     <= '0;
      r_d     <= '0;
      r_log_m <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mode  <= MODE_CORE;
      r_i     <= '0;
    end else begin
      r_state <= w_state_d;
      r_k     <= w_k_d;
      r_d     <= w_d_d;
      r_log_m <= w_log_m_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_mode  <= w_mode_d;
      r_i     <= w_i_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    w_k_d     = r_k;
    w_d_d     = r_d;
    w_log_m_d = r_log_m;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d = StRun;
          w_k_d     = '0;
          w_log_m_d = '0;
        end
      end
      StRun: begin
        if (r_k == AW'(WORDS - 1)) begin
          w_k_d     = '0;
          w_d_d     = '0;
          w_state_d = StDrain;
        end else begin
          w_k_d = r_k + 1'b1;
        end
      end
      StDrain: begin
        // Last drain cycle is also the last write-back of the stage.
        if (r_d == DW'(PIPE_LATENCY - 1)) begin
          w_d_d = '0;
          if (r_log_m == LOG_M_W'(NUM_STAGES - 1)) begin
            w_state_d = StDone;
          end else begin
            w_log_m_d = r_log_m + 1'b1;
            w_state_d = StRun;
          end
        end else begin
          w_d_d = r_d + 1'b1;
        end
      end
      StDone: begin
        w_state_d = StIdle;
        w_log_m_d = '0;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs, so mode and i move
  // in the same cycle as log_m and the read counter.
  always_comb begin
    w_busy_d = (w_state_d != StIdle);
    w_done_d = (w_state_d == StDone);
    w_mode_d = mode_of(w_log_m_d, MODE1_START, MODE2_START);
    w_i_d    = '0;
    if (w_mode_d == MODE_I && w_state_d == StRun) w_i_d = {1'b0, w_k_d};
  end

  // Gate the address so the delay line only ever carries zeros when idle.
  assign w_read_valid = (r_state == StRun);
  assign w_read_addr  = w_read_valid ? r_k : '0;

  ntt_ctrl_delay #(
    .WIDTH(AW + 1),
    .DEPTH(PIPE_LATENCY)
  ) u_wb_delay (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_d  ({w_read_valid, w_read_addr}),
    .o_q  (w_wb)
  );

  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign o_log_m               = r_log_m;
  assign o_i                   = r_i;
  assign o_mode                = r_mode;
  assign o_upper_read_address  = r_k;
  assign o_lower_read_address  = r_k;
  assign o_write_enable        = w_wb[AW];
  assign o_upper_write_address = w_wb[AW-1:0];
  assign o_lower_write_address = w_wb[AW-1:0];

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
module tb_ntt_stage_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] log_m;
    logic [1:0] mode;
    logic [9:0] i;
    logic [8:0] ura;
    logic [8:0] lra;
    logic       we;
    logic [8:0] uwa;
    logic [8:0] lwa;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, we;
  logic [3:0] log_m;
  logic [1:0] mode;
  logic [9:0] i_out;
  logic [8:0] ura, lra, uwa, lwa;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  ntt_stage_sequencer dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_start              (start),
    .o_busy               (busy),
    .o_done               (done),
    .o_log_m              (log_m),
    .o_i                  (i_out),
    .o_mode               (mode),
    .o_upper_read_address (ura),
    .o_lower_read_address (lra),
    .o_write_enable       (we),
    .o_upper_write_address(uwa),
    .o_lower_write_address(lwa)
  );

  function automatic out_t mk(input logic b, input logic d, input int lm, input int md,
                              input int iv, input int ra, input logic w, input int wa);
    out_t o;
    o.busy = b;  o.done = d;
    o.log_m = 4'(lm); o.mode = 2'(md); o.i = 10'(iv);
    o.ura = 9'(ra); o.lra = 9'(ra);
    o.we = w; o.uwa = 9'(wa); o.lwa = 9'(wa);
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.busy = busy; o.done = done; o.log_m = log_m; o.mode = mode; o.i = i_out;
    o.ura = ura; o.lra = lra; o.we = we; o.uwa = uwa; o.lwa = lwa;
    return o;
  endfunction

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got busy=%0b done=%0b log_m=%0d mode=%0d i=%0d ra=%0d/%0d we=%0b wa=%0d/%0d, expected busy=%0b done=%0b log_m=%0d mode=%0d i=%0d ra=%0d/%0d we=%0b wa=%0d/%0d",
                  name, act.busy, act.done, act.log_m, act.mode, act.i, act.ura, act.lra,
                  act.we, act.uwa, act.lwa, exp.busy, exp.done, exp.log_m, exp.mode, exp.i,
                  exp.ura, exp.lra, exp.we, exp.uwa, exp.lwa);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    int idle_err, vi, we_total, trk_err, done_cnt, done_cyc, busy_fall, late_busy, we_rst;
    int exp_mode;
    int we_stage [12];
    int last_wr [12];
    int stage_start [12];

    vecs[0]  = '{1,    mk(1, 0, 0,  0, 0,   0,   0, 0)};
    vecs[1]  = '{2,    mk(1, 0, 0,  0, 0,   1,   0, 0)};
    vecs[2]  = '{8,    mk(1, 0, 0,  0, 0,   7,   0, 0)};
    vecs[3]  = '{9,    mk(1, 0, 0,  0, 0,   8,   1, 0)};
    vecs[4]  = '{512,  mk(1, 0, 0,  0, 0,   511, 1, 503)};
    vecs[5]  = '{513,  mk(1, 0, 0,  0, 0,   0,   1, 504)};
    vecs[6]  = '{520,  mk(1, 0, 0,  0, 0,   0,   1, 511)};
    vecs[7]  = '{521,  mk(1, 0, 1,  0, 0,   0,   0, 0)};
    vecs[8]  = '{522,  mk(1, 0, 1,  0, 0,   1,   0, 0)};
    vecs[9]  = '{2601, mk(1, 0, 5,  1, 0,   0,   0, 0)};
    vecs[10] = '{2638, mk(1, 0, 5,  1, 37,  37,  1, 29)};
    vecs[11] = '{5192, mk(1, 0, 9,  1, 511, 511, 1, 503)};
    vecs[12] = '{5193, mk(1, 0, 9,  1, 0,   0,   1, 504)};
    vecs[13] = '{5201, mk(1, 0, 10, 2, 0,   0,   0, 0)};
    vecs[14] = '{5301, mk(1, 0, 10, 2, 0,   100, 1, 92)};
    vecs[15] = '{6240, mk(1, 0, 11, 2, 0,   0,   1, 511)};
    vecs[16] = '{6241, mk(1, 1, 11, 2, 0,   0,   0, 0)};
    vecs[17] = '{6242, mk(0, 0, 0,  0, 0,   0,   0, 0)};

    // Reset held 3 cycles, then 20 idle cycles.
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset_state", sample(), '0);
    rst = 1'b0;
    idle_err = 0;
    repeat (20) begin
      step();
      if (sample() !== '0) idle_err++;
    end
    chk_int("idle_outputs_nonzero_cycles", idle_err, 0);

    // Full transform, start at cycle 0.
    cyc = 0; vi = 0; we_total = 0; trk_err = 0; done_cnt = 0; done_cyc = -1; busy_fall = -1;
    for (int s = 0; s < 12; s++) begin
      we_stage[s] = 0; last_wr[s] = -1; stage_start[s] = -1;
    end
    start = 1'b1;
    while (cyc < 6250) begin
      step();
      start = 1'b0;
      if (vi < NV && vecs[vi].cyc == cyc) begin
        chk_out($sformatf("vec_cyc%0d", cyc), sample(), vecs[vi].exp);
        vi++;
      end
      if (we === 1'b1) begin
        we_total++;
        if (log_m < 12) begin
          we_stage[log_m]++;
          if (uwa == 9'd511) last_wr[log_m] = cyc;
        end
      end
      if (busy === 1'b1 && log_m < 12 && stage_start[log_m] < 0) stage_start[log_m] = cyc;
      if (busy !== 1'b1 && busy_fall < 0 && cyc > 1) busy_fall = cyc;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      exp_mode = (log_m < 5) ? 0 : (log_m < 10) ? 1 : 2;
      if (int'(mode) != exp_mode) trk_err++;
      if (i_out !== ((exp_mode == 1) ? {1'b0, ura} : 10'd0)) trk_err++;
    end
    chk_int("vectors_reached", vi, NV);
    chk_int("we_total", we_total, 6144);
    for (int s = 0; s < 12; s++) chk_int($sformatf("we_stage%0d", s), we_stage[s], 512);
    for (int s = 0; s < 12; s++)
      chk_int($sformatf("stage%0d_start", s), stage_start[s], 1 + 520 * s);
    for (int s = 0; s < 11; s++)
      chk_int($sformatf("hazard_stage%0d", s), int'(last_wr[s] >= 0 && last_wr[s] < stage_start[s+1]), 1);
    chk_int("done_count", done_cnt, 1);
    chk_int("done_cycle", done_cyc, 6241);
    chk_int("busy_fall_cycle", busy_fall, 6242);
    chk_int("mode_i_tracking_errors", trk_err, 0);

    // Start pulses during busy and during the DONE cycle are ignored.
    cyc = 0; done_cnt = 0; done_cyc = -1; late_busy = 0;
    start = 1'b1;
    while (cyc < 6300) begin
      step();
      start = (cyc == 100 || cyc == 3000 || cyc == 6241);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc >= 6242 && (busy !== 1'b0 || we !== 1'b0)) late_busy++;
    end
    start = 1'b0;
    chk_int("busy_start_done_count", done_cnt, 1);
    chk_int("busy_start_done_cycle", done_cyc, 6241);
    chk_int("no_second_transform", late_busy, 0);

    // Reset mid-run, then a fresh start at cycle 2010.
    cyc = 0; done_cnt = 0; done_cyc = -1; we_rst = 0;
    start = 1'b1;
    while (cyc < 8300) begin
      step();
      start = 1'b0;
      if (cyc == 2000) begin
        rst = 1'b1;
        #1;
        chk_out("async_reset_immediate", sample(), '0);
      end
      if (cyc == 2001) rst = 1'b0;
      if (cyc == 2010) start = 1'b1;
      if (cyc >= 2000 && cyc <= 2018 && we === 1'b1) we_rst++;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    start = 1'b0;
    chk_int("reset_no_stale_we", we_rst, 0);
    chk_int("restart_done_count", done_cnt, 1);
    chk_int("restart_done_cycle", done_cyc, 2010 + 6241);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
